// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access widths, FSM state
// encoding, error codes and small helpers for access-width normalisation.
package load_store_unit_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_t;

   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   // Unsigned variants make no sense for stores; anything illegal becomes W.
   function automatic logic [2:0] norm_funct3(input logic store, input logic [2:0] f3);
      logic [2:0] f;
      f = LS_W;
      case (f3)
         LS_B, LS_H, LS_W: f = f3;
         LS_BU, LS_HU:     f = store ? LS_W : f3;
         default:          f = LS_W;
      endcase
      return f;
   endfunction

   // Byte offset forced to the natural alignment of the access width.
   function automatic logic [1:0] natural_off(input logic [2:0] f3, input logic [1:0] off);
      logic [1:0] o;
      o = off;
      case (f3)
         LS_H, LS_HU: o = {off[1], 1'b0};
         LS_W:        o = 2'b00;
         default:     o = off;
      endcase
      return o;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3 == LS_H || f3 == LS_HU) && off[0]) || (f3 == LS_W && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the load/store unit. Store side produces byte
// strobes and lane-replicated write data; load side extracts the addressed
// lane and sign/zero-extends it. Purely combinational.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Store path: strobes and replicated write data per access width
   always_comb begin
      wstrb = 4'b1111;
      wdata = store_data;
      case (funct3)
         LS_B: begin
            wstrb = 4'b0001 << byte_off;
            wdata = {4{store_data[7:0]}};
         end
         LS_H: begin
            wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            wstrb = 4'b1111;
            wdata = store_data;
         end
      endcase
   end

   // Load path: pick the addressed lane and extend it to 32 bits
   always_comb begin
      lane_b = load_word[7:0];
      case (byte_off)
         2'd0: lane_b = load_word[7:0];
         2'd1: lane_b = load_word[15:8];
         2'd2: lane_b = load_word[23:16];
         2'd3: lane_b = load_word[31:24];
         default: lane_b = load_word[7:0];
      endcase
      lane_h = byte_off[1] ? load_word[31:16] : load_word[15:0];
      case (funct3)
         LS_B:    load_data = {{24{lane_b[7]}}, lane_b};
         LS_BU:   load_data = {24'd0, lane_b};
         LS_H:    load_data = {{16{lane_h[15]}}, lane_h};
         LS_HU:   load_data = {16'd0, lane_h};
         default: load_data = load_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between execute and a req/gnt/rvalid data
// memory port. Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip
// memory and report err_code 01; otherwise low address bits are forced to
// natural alignment.
// Handshakes: a request is accepted on a rising edge where req_valid &&
// req_ready; mem_req is held with stable address/data until mem_gnt is seen
// high at an edge; mem_rvalid is only honoured in WAIT_R (never in the gnt
// cycle). dbg_state exposes the FSM state for checkers.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       store_data,
   input  logic [4:0]        rd,
   output logic              stall,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = (TIMEOUT < 15) ? 4 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   lsu_state_t        state, state_n;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] word_q;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic              store_q;
   logic              mis_q;
   logic [31:0]       sdata_q;
   logic [31:0]       rdata_q;

   logic [2:0]        f3_n;
   logic [1:0]        off_n;
   logic              mis_n;
   logic              accept;
   logic              timed_out;
   logic [3:0]        st_wstrb;
   logic [31:0]       st_wdata;
   logic [31:0]       ld_data;
   logic [31:0]       unused_st_load;
   logic [3:0]        unused_ld_wstrb;
   logic [31:0]       unused_ld_wdata;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^addr[31:ADDR_W+2];
   assign accept         = req_valid && (state == ST_IDLE);
   assign timed_out      = (cnt_q == TMO);
   assign f3_n           = norm_funct3(is_store, funct3);
   assign dbg_state      = state;

`ifdef LSU_MISALIGN_TRAP_EN
   assign off_n = addr[1:0];
   assign mis_n = is_misaligned(f3_n, addr[1:0]);
`else
   assign off_n = natural_off(f3_n, addr[1:0]);
   assign mis_n = 1'b0;
`endif

   lsu_lane_align u_store_align (
      .funct3     (f3_q),
      .byte_off   (off_q),
      .store_data (sdata_q),
      .load_word  (32'd0),
      .wstrb      (st_wstrb),
      .wdata      (st_wdata),
      .load_data  (unused_st_load)
   );

   lsu_lane_align u_load_align (
      .funct3     (f3_q),
      .byte_off   (off_q),
      .store_data (32'd0),
      .load_word  (rdata_q),
      .wstrb      (unused_ld_wstrb),
      .wdata      (unused_ld_wdata),
      .load_data  (ld_data)
   );

   // State register, timeout counter and latched request fields
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         store_q <= 1'b0;
         mis_q   <= 1'b0;
         sdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (state_n != state && (state_n == ST_REQ || state_n == ST_WAIT_R))
            cnt_q <= '0;
         else if ((state == ST_REQ || state == ST_WAIT_R) && !timed_out)
            cnt_q <= cnt_q + 1'b1;
         if (accept) begin
            word_q  <= addr[ADDR_W+1:2];
            off_q   <= off_n;
            f3_q    <= f3_n;
            rd_q    <= rd;
            store_q <= is_store;
            mis_q   <= mis_n;
            sdata_q <= store_data;
         end
         if (state == ST_WAIT_R && mem_rvalid && !timed_out)
            rdata_q <= mem_rdata;
      end
   end

   // Next-state and Moore outputs derived from state and latched fields
   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      stall     = 1'b1;
      mem_req   = 1'b0;
      wb_valid  = 1'b0;
      err_valid = 1'b0;
      err_code  = 2'b00;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            stall     = 1'b0;
            if (req_valid) state_n = mis_n ? ST_RESP : ST_REQ;
         end
         ST_REQ: begin
            if (timed_out) begin
               err_valid = 1'b1;
               err_code  = ERR_TIMEOUT;
               state_n   = ST_IDLE;
            end else begin
               mem_req = 1'b1;
               if (mem_gnt) state_n = store_q ? ST_RESP : ST_WAIT_R;
            end
         end
         ST_WAIT_R: begin
            if (timed_out) begin
               err_valid = 1'b1;
               err_code  = ERR_TIMEOUT;
               state_n   = ST_IDLE;
            end else if (mem_rvalid) begin
               state_n = ST_RESP;
            end
         end
         ST_RESP: begin
            state_n = ST_IDLE;
            if (mis_q) begin
               err_valid = 1'b1;
               err_code  = ERR_MISALIGN;
            end else if (!store_q) begin
               wb_valid = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign mem_we    = mem_req && store_q;
   assign mem_addr  = mem_req ? word_q : '0;
   assign mem_wstrb = mem_req ? st_wstrb : 4'd0;
   assign mem_wdata = mem_req ? st_wdata : 32'd0;
   assign wb_rd     = wb_valid ? rd_q : 5'd0;
   assign wb_data   = wb_valid ? ld_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Inputs are driven and outputs
// sampled on the falling edge. Writeback/error pulses are matched against an
// expected queue; each scenario task checks memory-port and timing inline.
module tb_load_store_unit;

   localparam int W = 39; // {kind[1:0], rd[4:0], data[31:0]}, kind 0 = wb, 1 = err

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_valid;
   logic [1:0]  err_code;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_obs;

   // values seen on the memory port at the grant cycle
   logic        obs_we;
   logic [7:0]  obs_addr;
   logic [3:0]  obs_wstrb;
   logic [31:0] obs_wdata;
   logic        obs_unstable;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .rd         (rd),
      .stall      (stall),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .dbg_state  (dbg_state)
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard: every wb/err pulse must match the head of the expected queue
   always @(negedge clk) begin
      if (wb_valid || err_valid) begin
         checks++;
         mon_obs = wb_valid ? {2'd0, wb_rd, wb_data} : {2'd1, 5'd0, 30'd0, err_code};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got %h required no pulse", mon_obs);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_obs !== mon_exp) begin
               errors++;
               $display("FAIL sb_result got %h required %h", mon_obs, mon_exp);
            end
         end
      end
   end

   function automatic logic [W-1:0] exp_wb(input logic [4:0] r, input logic [31:0] d);
      return {2'd0, r, d};
   endfunction

   function automatic logic [W-1:0] exp_err(input logic [1:0] code);
      return {2'd1, 5'd0, 30'd0, code};
   endfunction

   // reference load result derived from the access description
   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] a_lo,
                                              input logic [31:0] word);
      logic [1:0]  off;
      logic [31:0] s;
      off = a_lo;
`ifndef LSU_MISALIGN_TRAP_EN
      if (f == 3'b001 || f == 3'b101) off[0] = 1'b0;
      if (f == 3'b010) off = 2'b00;
`endif
      s = word >> (8 * off);
      case (f)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b100:  return {24'd0, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b101:  return {16'd0, s[15:0]};
         default: return word;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL issue_ready got req_ready=%0b required 1", req_ready);
      end
      req_valid  = 1'b1;
      is_store   = st;
      funct3     = f;
      addr       = a;
      store_data = d;
      rd         = r;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   // memory model: grant after gnt_dly cycles, then rvalid after rv_dly (<0: never)
   task automatic mem_serve(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
      int n;
      logic [7:0] first_addr;
      n = 0;
      obs_unstable = 1'b0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!mem_req) begin
         errors++;
         $display("FAIL serve_req got mem_req=%0b required 1", mem_req);
      end else begin
         first_addr = mem_addr;
         repeat (gnt_dly) begin
            @(negedge clk);
            if (!mem_req || mem_addr !== first_addr) obs_unstable = 1'b1;
         end
         obs_we    = mem_we;
         obs_addr  = mem_addr;
         obs_wstrb = mem_wstrb;
         obs_wdata = mem_wdata;
         mem_gnt    = 1'b1;
         mem_rvalid = 1'b1;   // same-cycle rvalid must be ignored
         mem_rdata  = 32'hBAD0_BAD0;
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         if (rv_dly >= 0) begin
            repeat (rv_dly) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending required 0", exp_q.size());
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [88:0] obs;
      logic [88:0] exp_v;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      exp_v = {1'b1, 88'd0};
      obs = {req_ready, stall, wb_valid, wb_rd, wb_data, err_valid, err_code,
             mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_outputs got %h required %h", obs, exp_v);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state got %0d required 0", dbg_state);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_store_word();
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
      mem_serve(0, -1, 32'd0);
      checks++;
      if ({obs_we, obs_addr, obs_wstrb, obs_wdata} !== {1'b1, 8'd4, 4'b1111, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL store_w_port got we=%0b addr=%h strb=%b data=%h required 1 04 1111 deadbeef",
                  obs_we, obs_addr, obs_wstrb, obs_wdata);
      end
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL store_w_resp_stall got %0b required 1", stall);
      end
      @(negedge clk);
      checks++;
      if ({stall, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL store_w_release got stall=%0b ready=%0b required 0 1", stall, req_ready);
      end
   endtask

   task automatic test_load_byte();
      exp_q.push_back(exp_wb(5'd7, 32'hFFFFFF80));
      issue(1'b0, 3'b000, 32'h13, 32'd0, 5'd7);
      mem_serve(0, 0, 32'h80000000);
      checks++;
      if ({obs_we, obs_addr} !== {1'b0, 8'd4}) begin
         errors++;
         $display("FAIL load_b_port got we=%0b addr=%h required 0 04", obs_we, obs_addr);
      end
      drain();
      exp_q.push_back(exp_wb(5'd7, 32'h00000080));
      issue(1'b0, 3'b100, 32'h13, 32'd0, 5'd7);
      mem_serve(1, 2, 32'h80000000);
      drain();
   endtask

   task automatic test_half();
      issue(1'b1, 3'b001, 32'h2, 32'h1234ABCD, 5'd0);
      mem_serve(2, -1, 32'd0);
      checks++;
      if ({obs_wstrb, obs_wdata} !== {4'b1100, 32'hABCDABCD}) begin
         errors++;
         $display("FAIL store_h_port got strb=%b data=%h required 1100 abcdabcd", obs_wstrb, obs_wdata);
      end
      checks++;
      if (obs_unstable !== 1'b0) begin
         errors++;
         $display("FAIL store_h_stable got unstable=%0b required 0", obs_unstable);
      end
      @(negedge clk);
      exp_q.push_back(exp_wb(5'd9, 32'h0000ABCD));
      issue(1'b0, 3'b101, 32'h2, 32'd0, 5'd9);
      mem_serve(0, 1, 32'hABCD0000);
      drain();
      exp_q.push_back(exp_wb(5'd10, 32'hFFFF8001));
      issue(1'b0, 3'b001, 32'h0, 32'd0, 5'd10);
      mem_serve(0, 0, 32'h12348001);
      drain();
   endtask

   task automatic test_illegal_funct3();
      issue(1'b1, 3'b100, 32'h20, 32'hCAFEF00D, 5'd0);
      mem_serve(0, -1, 32'd0);
      checks++;
      if ({obs_addr, obs_wstrb, obs_wdata} !== {8'd8, 4'b1111, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL illegal_store_f3 got addr=%h strb=%b data=%h required 08 1111 cafef00d",
                  obs_addr, obs_wstrb, obs_wdata);
      end
      @(negedge clk);
      exp_q.push_back(exp_wb(5'd11, 32'h87654321));
      issue(1'b0, 3'b011, 32'h24, 32'd0, 5'd11);
      mem_serve(0, 0, 32'h87654321);
      drain();
   endtask

   task automatic test_timeout();
      int n;
      exp_q.push_back(exp_err(2'b10));
      issue(1'b0, 3'b010, 32'h30, 32'd0, 5'd4);
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL timeout_req_cycles got %0d required 15", n);
      end
      checks++;
      if ({err_valid, err_code, mem_req} !== {1'b1, 2'b10, 1'b0}) begin
         errors++;
         $display("FAIL timeout_err got err=%0b code=%b req=%0b required 1 10 0",
                  err_valid, err_code, mem_req);
      end
      @(negedge clk);
      checks++;
      if ({req_ready, stall} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_idle got ready=%0b stall=%0b required 1 0", req_ready, stall);
      end
      // rvalid never comes: WAIT_R must time out as well
      exp_q.push_back(exp_err(2'b10));
      issue(1'b0, 3'b010, 32'h34, 32'd0, 5'd5);
      mem_serve(0, -1, 32'd0);
      drain();
      // the unit takes new work afterwards
      issue(1'b1, 3'b000, 32'h41, 32'h000000A5, 5'd0);
      mem_serve(0, -1, 32'd0);
      checks++;
      if ({obs_addr, obs_wstrb, obs_wdata} !== {8'h10, 4'b0010, 32'hA5A5A5A5}) begin
         errors++;
         $display("FAIL post_timeout_store got addr=%h strb=%b data=%h required 10 0010 a5a5a5a5",
                  obs_addr, obs_wstrb, obs_wdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [88:0] obs;
      logic [88:0] exp_v;
      logic        bad;
      issue(1'b0, 3'b010, 32'h50, 32'd0, 5'd6);
      mem_serve(0, -1, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      exp_v = {1'b1, 88'd0};
      obs = {req_ready, stall, wb_valid, wb_rd, wb_data, err_valid, err_code,
             mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_outputs got %h required %h", obs, exp_v);
      end
      reset = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h11111111;
      @(negedge clk);
      mem_rvalid = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         if (wb_valid || err_valid || !req_ready) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet got activity=%0b required 0", bad);
      end
   endtask

   task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
      exp_q.push_back(exp_err(2'b01));
      issue(1'b0, 3'b010, 32'h6, 32'd0, 5'd3);
      checks++;
      if ({err_valid, err_code, mem_req} !== {1'b1, 2'b01, 1'b0}) begin
         errors++;
         $display("FAIL misalign_trap got err=%0b code=%b req=%0b required 1 01 0",
                  err_valid, err_code, mem_req);
      end
      @(negedge clk);
`else
      exp_q.push_back(exp_wb(5'd3, 32'h01020304));
      issue(1'b0, 3'b010, 32'h6, 32'd0, 5'd3);
      mem_serve(0, 0, 32'h01020304);
      checks++;
      if (obs_addr !== 8'd1) begin
         errors++;
         $display("FAIL misalign_addr got %h required 01", obs_addr);
      end
      drain();
`endif
   endtask

   task automatic test_random();
      logic [2:0]  ld_tab [5];
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rw;
      logic [4:0]  r;
      logic        st;
      logic        mis;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [1:0]  off;
      ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int i = 0; i < 16; i++) begin
         st = 1'($urandom_range(0, 1));
         f  = st ? ld_tab[$urandom_range(0, 2)] : ld_tab[$urandom_range(0, 4)];
         a  = 32'($urandom_range(0, 1023));
         d  = $urandom;
         rw = $urandom;
         r  = 5'($urandom_range(1, 31));
         mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis = ((f == 3'b001 || f == 3'b101) && a[0]) || (f == 3'b010 && a[1:0] != 2'b00);
`endif
         if (mis) begin
            exp_q.push_back(exp_err(2'b01));
            issue(st, f, a, d, r);
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL rand_mis_req got %0b required 0", mem_req);
            end
            @(negedge clk);
         end else if (st) begin
            off = a[1:0];
            if (f == 3'b001) off[0] = 1'b0;
            case (f)
               3'b000: begin e_strb = 4'b0001 << off; e_wdata = {4{d[7:0]}}; end
               3'b001: begin e_strb = off[1] ? 4'b1100 : 4'b0011; e_wdata = {2{d[15:0]}}; end
               default: begin e_strb = 4'b1111; e_wdata = d; end
            endcase
            issue(st, f, a, d, r);
            mem_serve($urandom_range(0, 3), -1, 32'd0);
            checks++;
            if ({obs_we, obs_addr, obs_wstrb, obs_wdata, obs_unstable} !==
                {1'b1, a[9:2], e_strb, e_wdata, 1'b0}) begin
               errors++;
               $display("FAIL rand_store got we=%0b addr=%h strb=%b data=%h unst=%0b required 1 %h %b %h 0",
                        obs_we, obs_addr, obs_wstrb, obs_wdata, obs_unstable, a[9:2], e_strb, e_wdata);
            end
            @(negedge clk);
         end else begin
            exp_q.push_back(exp_wb(r, model_load(f, a[1:0], rw)));
            issue(st, f, a, d, r);
            mem_serve($urandom_range(0, 3), $urandom_range(0, 3), rw);
            checks++;
            if ({obs_we, obs_addr} !== {1'b0, a[9:2]}) begin
               errors++;
               $display("FAIL rand_load_port got we=%0b addr=%h required 0 %h", obs_we, obs_addr, a[9:2]);
            end
            drain();
         end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      reset      = 1'b0;
      req_valid  = 1'b0;
      is_store   = 1'b0;
      funct3     = 3'b000;
      addr       = 32'd0;
      store_data = 32'd0;
      rd         = 5'd0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      obs_we     = 1'b0;
      obs_addr   = 8'd0;
      obs_wstrb  = 4'd0;
      obs_wdata  = 32'd0;
      obs_unstable = 1'b0;
      repeat (2) @(negedge clk);

      test_reset();
      test_store_word();
      test_load_byte();
      test_half();
      test_illegal_funct3();
      test_timeout();
      test_reset_mid();
      test_misalign();
      test_random();

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage directly downstream of the core's execute stage.
- Consumes the effective address (ALU output), funct3, store data and rd for Load/Store instructions.
- Drives a request/grant/rvalid data-memory port with byte-lane strobes.
- Returns an aligned, sign- or zero-extended writeback word and holds the core in stall while busy. Replaces the single-cycle word-only SystemMemory access.

Parameters:
- ADDR_W, 8, word-address width on the memory port (256-word data memory).
- TIMEOUT, 15, maximum cycles waiting for mem_gnt or mem_rvalid before a bus error; 4-bit counter minimum.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  execute stage presents a Load or Store.
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  effective byte address.
- store_data  in  32  rs2 value.
- rd  in  5  load destination register.
- stall  out  1  core must hold PC and register writes.
- wb_valid  out  1  one-cycle pulse; load data valid.
- wb_rd  out  5  destination register for wb_data.
- wb_data  out  32  extended load result.
- err_valid  out  1  one-cycle pulse; misaligned access or bus timeout.
- err_code  out  2  01 misaligned, 10 timeout.
- mem_req  out  1  request to memory; held until mem_gnt.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address, addr[ADDR_W+1:2].
- mem_wstrb  out  4  byte enables.
- mem_wdata  out  32  store data replicated to lanes.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  read data valid, at least one cycle after mem_gnt.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - All outputs 0 except req_ready=1.
  - Counter and latched fields are cleared.
  - Reset mid-transaction abandons it with no wb_valid or err_valid.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - On accept, latch addr, funct3, rd, is_store and store_data.
  - Compute strobes: B = 1<<addr[1:0]; H = 0011 or 1100 by addr[1]; W = 1111.
  - Compute wdata: B replicated ×4, H replicated ×2, W as-is.
  - Transition to REQ. stall=1 from the cycle after accept until the cycle wb_valid or err_valid pulses, inclusive.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_gnt.
  - On gnt with a store: go to RESP (no wb_valid).
  - On gnt with a load: go to WAIT_R.
  - mem_rvalid in the same cycle as gnt is ignored.
- WAIT_R: on mem_rvalid, capture rdata and go to RESP.
- RESP: one cycle, then IDLE.
  - Load: wb_valid=1, with wb_data = lane selected by the latched addr[1:0], sign-extended for B/H and zero-extended for BU/HU.
  - Store: pulse only releases stall.
- Throughput: best case is 3 cycles for a store (accept, REQ+gnt, RESP) and 4 for a load.
- Timeout:
  - Counter resets on entering REQ or WAIT_R and increments each cycle there.
  - When it reaches TIMEOUT with no gnt/rvalid: err_valid=1, err_code=10, mem_req dropped, state to IDLE, no wb_valid.
- funct3 outside the legal set for the access type is treated as W.
- req_valid while not ready is ignored; the core holds it under stall.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0]!=0, skips memory.
  - Goes straight IDLE→RESP, err_valid=1, err_code=01, no wb_valid, no mem_req.
- Undefined:
  - Low address bits are forced to natural alignment (H clears bit 0, W clears bits 1:0).
  - Access proceeds normally; err_code 01 is never produced.

Decomposition:
- Shared package:
  - funct3 width constants LS_B/LS_H/LS_W/LS_BU/LS_HU.
  - FSM state encoding.
  - err_code constants.
  - Shared with the decoder and ALU.
- Sub-module lsu_lane_align: purely combinational.
  - Store path: strobe/wdata generation.
  - Load path: lane extraction/extension.
  - Instanced once for each path.

Test Plan:
- Store W: addr 0x10, data 0xDEADBEEF, gnt 1 cycle after req → mem_addr 4, wstrb 1111, wdata 0xDEADBEEF, no wb_valid, stall released 3 cycles after accept.
- Load B: addr 0x13, rdata 0x80000000 → wb_data 0xFFFFFF80; same access as BU → 0x00000080; rd 7 → wb_rd 7.
- Store H at addr 0x2: data 0x1234ABCD → wstrb 1100, wdata 0xABCDABCD; then load HU at 0x2 with rdata 0xABCD0000 → wb_data 0x0000ABCD.
- Timeout: mem_gnt held 0 → err_valid with err_code 10 after 15 REQ cycles, mem_req drops, next request accepted.
- Reset pulled low in WAIT_R, then released → no wb_valid, req_ready=1, all outputs 0; rvalid arriving after reset is ignored.
- LSU_MISALIGN_TRAP_EN: load W at 0x6 → err_code 01 two cycles after accept, mem_req never asserted; without the macro → mem_addr 1 and normal wb_valid.
